pipeline_sequencer: RTL and testbench

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_sequencer_if.sv | 51 +++++
 rtl/pipeline_sequencer.sv | 132 +++++++++++++
 tb/tb_pipeline_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_sequencer_if.sv
// ============================================================================
// Module      : pipeline_sequencer_if
// Description : Handshake bundle between the hazard/step sequencer and the
//               five-stage pipeline it controls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_sequencer_if;
  logic        step;
  logic        run_mode;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_UsesRt;
  logic        ID_Halt;
  logic        EX_MemRead;
  logic [4:0]  EX_Rt;
  logic        MEM_BranchTaken;

  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        memwb_flush;
  logic [1:0]  state;
  logic [15:0] step_count;
  logic [7:0]  stall_count;
  logic [7:0]  flush_count;

  modport master (
    output step, run_mode, ID_Rs, ID_Rt, ID_UsesRt, ID_Halt,
           EX_MemRead, EX_Rt, MEM_BranchTaken,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           state, step_count, stall_count, flush_count
  );

  modport slave (
    input  step, run_mode, ID_Rs, ID_Rt, ID_UsesRt, ID_Halt,
           EX_MemRead, EX_Rt, MEM_BranchTaken,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           state, step_count, stall_count, flush_count
  );
endinterface

`default_nettype wire

// File: rtl/pipeline_sequencer.sv
// ============================================================================
// Module      : pipeline_sequencer
// Description : Registered advance/flush controller for a five-stage pipeline
//               with single-step, load-use stall and taken-branch flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_sequencer (
  input  logic                 clock,
  input  logic                 reset,
  pipeline_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [4:0] C_EN_ALL   = 5'b11111;
  localparam logic [4:0] C_EN_STALL = 5'b00011;
  localparam logic [3:0] C_FL_ALL   = 4'b1111;
  localparam logic [3:0] C_FL_BR    = 4'b1110;
  localparam logic [3:0] C_FL_STALL = 4'b0100;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_init_cnt, w_init_cnt_nxt;
  logic [4:0]  r_en, w_en_nxt;   // {pc, ifid, idex, exmem, memwb}
  logic [3:0]  r_fl, w_fl_nxt;   // {ifid, idex, exmem, memwb}
  logic [15:0] r_step_cnt;
  logic [7:0]  r_stall_cnt;
  logic [7:0]  r_flush_cnt;
  logic        w_inc_step, w_inc_stall, w_inc_flush;
  logic        w_req, w_load_use;

  assign w_req      = bus.run_mode | bus.step;
  assign w_load_use = bus.EX_MemRead && (bus.EX_Rt != 5'd0) &&
                      ((bus.EX_Rt == bus.ID_Rs) ||
                       (bus.ID_UsesRt && (bus.EX_Rt == bus.ID_Rt)));

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_en_nxt       = 5'b00000;
    w_fl_nxt       = 4'b0000;
    w_inc_step     = 1'b0;
    w_inc_stall    = 1'b0;
    w_inc_flush    = 1'b0;
    case (r_state)
      S_INIT: begin
        // Counter value 3 marks the fourth flush cycle; outputs drop as RUN begins.
        if (r_init_cnt == 2'd3) begin
          w_state_nxt    = S_RUN;
          w_init_cnt_nxt = 2'd0;
        end else begin
          w_fl_nxt       = C_FL_ALL;
          w_init_cnt_nxt = r_init_cnt + 2'd1;
        end
      end
      S_RUN: begin
        if (w_req) begin
          w_inc_step = 1'b1;
          if (bus.MEM_BranchTaken) begin
            w_en_nxt    = C_EN_ALL;
            w_fl_nxt    = C_FL_BR;
            w_inc_flush = 1'b1;
          end else if (w_load_use) begin
            w_en_nxt    = C_EN_STALL;
            w_fl_nxt    = C_FL_STALL;
            w_inc_stall = 1'b1;
          end else begin
            w_en_nxt = C_EN_ALL;
            if (bus.ID_Halt) begin
              w_state_nxt = S_HALT;
            end
          end
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt    = S_INIT;
        w_init_cnt_nxt = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_init_cnt  <= 2'd0;
      r_en        <= 5'b00000;
      r_fl        <= C_FL_ALL;
      r_step_cnt  <= 16'd0;
      r_stall_cnt <= 8'd0;
      r_flush_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
      r_en       <= w_en_nxt;
      r_fl       <= w_fl_nxt;
      if (w_inc_step) begin
        r_step_cnt <= r_step_cnt + 16'd1;
      end
      if (w_inc_stall && (r_stall_cnt != 8'hFF)) begin
        r_stall_cnt <= r_stall_cnt + 8'd1;
      end
      if (w_inc_flush && (r_flush_cnt != 8'hFF)) begin
        r_flush_cnt <= r_flush_cnt + 8'd1;
      end
    end
  end

  assign bus.pc_en       = r_en[4];
  assign bus.ifid_en     = r_en[3];
  assign bus.idex_en     = r_en[2];
  assign bus.exmem_en    = r_en[1];
  assign bus.memwb_en    = r_en[0];
  assign bus.ifid_flush  = r_fl[3];
  assign bus.idex_flush  = r_fl[2];
  assign bus.exmem_flush = r_fl[1];
  assign bus.memwb_flush = r_fl[0];
  assign bus.state       = r_state;
  assign bus.step_count  = r_step_cnt;
  assign bus.stall_count = r_stall_cnt;
  assign bus.flush_count = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
// ============================================================================
// Module      : tb_pipeline_sequencer
// Description : Directed scoreboard bench for pipeline_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_sequencer;

  // Control vector {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem,memwb flushes}
  localparam logic [8:0] C_IDLE   = 9'b00000_0000;
  localparam logic [8:0] C_INIT   = 9'b00000_1111;
  localparam logic [8:0] C_NORM   = 9'b11111_0000;
  localparam logic [8:0] C_STALL  = 9'b00011_0100;
  localparam logic [8:0] C_BRANCH = 9'b11111_1110;

  typedef struct {
    string      tag;
    logic [8:0] ctl;
    logic [1:0] st;
  } exp_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_fail;
  int   n_total;
  exp_t sb[$];

  pipeline_sequencer_if bus ();

  pipeline_sequencer dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ctl_now();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_next(input string tag, input logic [8:0] ctl, input logic [1:0] st);
    exp_t e;
    e.tag = tag;
    e.ctl = ctl;
    e.st  = st;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, " ctl"}, {23'd0, ctl_now()}, {23'd0, e.ctl});
      chk({e.tag, " state"}, {30'd0, bus.state}, {30'd0, e.st});
    end
  endtask

  task automatic clear_hazards();
    bus.ID_Rs           = 5'd0;
    bus.ID_Rt           = 5'd0;
    bus.ID_UsesRt       = 1'b0;
    bus.ID_Halt         = 1'b0;
    bus.EX_MemRead      = 1'b0;
    bus.EX_Rt           = 5'd0;
    bus.MEM_BranchTaken = 1'b0;
  endtask

  task automatic do_reset_and_init();
    rst = 1'b1;
    expect_next("reset", C_INIT, 2'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_next("init", C_INIT, 2'd0);
      tick();
    end
    expect_next("init_to_run", C_IDLE, 2'd1);
    tick();
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    rst = 1'b1;
    bus.step = 1'b0;
    bus.run_mode = 1'b0;
    clear_hazards();
    @(posedge clk);
    #1;

    // Reset release and 4-cycle INIT
    do_reset_and_init();
    chk("step_count after init", {16'd0, bus.step_count}, 32'd0);
    chk("stall_count after init", {24'd0, bus.stall_count}, 32'd0);
    chk("flush_count after init", {24'd0, bus.flush_count}, 32'd0);

    // Three single-step pulses, five cycles apart
    for (int k = 0; k < 3; k++) begin
      bus.step = 1'b1;
      expect_next("step_pulse", C_NORM, 2'd1);
      tick();
      bus.step = 1'b0;
      for (int j = 0; j < 4; j++) begin
        expect_next("step_idle", C_IDLE, 2'd1);
        tick();
      end
    end
    chk("step_count after 3 steps", {16'd0, bus.step_count}, 32'd3);

    // Load-use on Rs in run mode
    bus.run_mode = 1'b1;
    bus.EX_MemRead = 1'b1; bus.EX_Rt = 5'd5; bus.ID_Rs = 5'd5;
    expect_next("loaduse_rs", C_STALL, 2'd1);
    tick();
    chk("stall_count first", {24'd0, bus.stall_count}, 32'd1);
    chk("step_count with stall", {16'd0, bus.step_count}, 32'd4);

    // Rt=0 never forms a hazard
    bus.EX_Rt = 5'd0; bus.ID_Rs = 5'd0;
    expect_next("loaduse_r0", C_NORM, 2'd1);
    tick();

    // Rt match only counts when ID reads Rt
    bus.EX_Rt = 5'd7; bus.ID_Rs = 5'd1; bus.ID_Rt = 5'd7; bus.ID_UsesRt = 1'b0;
    expect_next("rt_unused", C_NORM, 2'd1);
    tick();
    bus.ID_UsesRt = 1'b1;
    expect_next("rt_used", C_STALL, 2'd1);
    tick();

    // Branch wins over load-use and halt
    bus.MEM_BranchTaken = 1'b1; bus.ID_Halt = 1'b1;
    expect_next("branch_prio", C_BRANCH, 2'd1);
    tick();
    chk("flush_count branch", {24'd0, bus.flush_count}, 32'd1);
    chk("stall_count unchanged by branch", {24'd0, bus.stall_count}, 32'd2);
    chk("step_count after branch", {16'd0, bus.step_count}, 32'd8);

    clear_hazards();
    expect_next("run_free", C_NORM, 2'd1);
    tick();
    bus.run_mode = 1'b0;
    expect_next("run_mode_off", C_IDLE, 2'd1);
    tick();

    // Halt: one normal advance, then frozen until reset
    bus.run_mode = 1'b1; bus.ID_Halt = 1'b1;
    expect_next("halt_advance", C_NORM, 2'd2);
    tick();
    bus.ID_Halt = 1'b0;
    expect_next("halt_runmode", C_IDLE, 2'd2);
    tick();
    bus.run_mode = 1'b0; bus.step = 1'b1;
    expect_next("halt_step", C_IDLE, 2'd2);
    tick();
    bus.step = 1'b0;
    expect_next("halt_idle", C_IDLE, 2'd2);
    tick();
    chk("step_count in halt", {16'd0, bus.step_count}, 32'd10);

    // Reset out of HALT; a step during INIT is dropped
    rst = 1'b1;
    expect_next("reset_from_halt", C_INIT, 2'd0);
    tick();
    rst = 1'b0;
    chk("step_count cleared", {16'd0, bus.step_count}, 32'd0);
    chk("flush_count cleared", {24'd0, bus.flush_count}, 32'd0);
    bus.step = 1'b1;
    expect_next("init_step_drop", C_INIT, 2'd0);
    tick();
    bus.step = 1'b0;
    expect_next("init2", C_INIT, 2'd0);
    tick();
    expect_next("init3", C_INIT, 2'd0);
    tick();
    expect_next("init_done", C_IDLE, 2'd1);
    tick();
    expect_next("no_queued_step", C_IDLE, 2'd1);
    tick();

    // Halt together with load-use stalls and stays in RUN
    bus.run_mode = 1'b1; bus.ID_Halt = 1'b1;
    bus.EX_MemRead = 1'b1; bus.EX_Rt = 5'd3; bus.ID_Rs = 5'd3;
    expect_next("halt_loaduse", C_STALL, 2'd1);
    tick();
    clear_hazards();
    bus.run_mode = 1'b0;
    expect_next("after_halt_stall", C_IDLE, 2'd1);
    tick();

    // step_count wrap and stall_count saturation
    do_reset_and_init();
    bus.run_mode = 1'b1;
    repeat (65535) tick();
    chk("step_count max", {16'd0, bus.step_count}, 32'd65535);
    expect_next("wrap_advance", C_NORM, 2'd1);
    tick();
    chk("step_count wrap", {16'd0, bus.step_count}, 32'd0);
    bus.EX_MemRead = 1'b1; bus.EX_Rt = 5'd9; bus.ID_Rs = 5'd9;
    repeat (300) tick();
    chk("stall_count saturate", {24'd0, bus.stall_count}, 32'd255);
    chk("stall ctl held", {23'd0, ctl_now()}, {23'd0, C_STALL});
    chk("flush_count idle", {24'd0, bus.flush_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
